fetch_sequencer: RTL

- Controller that sequences the program-counter register and the instruction-memory fetch port of the 32-bit MIPS core.
- Launches one instruction fetch at a time over a req/ack handshake and buffers the returned word for decode.
- Holds on pipeline stall; redirects on branch/jump or exception, discarding any in-flight fetch.
- Sits between the instruction memory and the IF/ID stage; the word-addressed PC increments by PC_STEP.

---
 rtl/fetch_seq_pkg.sv | 18 +
 rtl/pc_next_reg.sv | 27 ++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_seq_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  // BOOT: post-reset settle cycle. ISSUE: idle, ready to launch a fetch.
  // BUSY: fetch outstanding. FLUSH: fetch outstanding, its data is dropped.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_reg.sv
// Program-counter register: load has priority over increment, else hold.
module pc_next_reg
  import fetch_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VALUE = DEF_RESET_VECTOR,
  parameter logic [PC_W-1:0] STEP        = 32'd1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_value,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // PC update; increment wraps modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VALUE;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding req/ack fetch, single-entry
// output buffer toward IF/ID, redirect on branch/jump or exception.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [PC_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter logic [PC_W-1:0] PC_STEP      = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] pc_out
);

  fetch_state_t    state;
  logic [PC_W-1:0] req_addr;
  logic [PC_W-1:0] pc;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            buf_free;
  logic            load_buf;

  // Redirect selection, buffer availability and accepted-fetch decode
  always_comb begin
    redirect    = exc_valid | branch_valid;
    redirect_pc = exc_valid ? EXC_VECTOR : branch_target;
    buf_free    = !if_valid || !stall;
    load_buf    = (state == ST_BUSY) && imem_ack && !redirect;
    imem_req    = (state == ST_BUSY) || (state == ST_FLUSH);
    imem_addr   = req_addr;
    pc_out      = pc;
  end

  pc_next_reg #(
    .RESET_VALUE (RESET_VECTOR),
    .STEP        (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (redirect),
    .load_value (redirect_pc),
    .inc        (load_buf),
    .pc         (pc)
  );

  // Fetch FSM and latched request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      req_addr <= '0;
    end else begin
      case (state)
        ST_BOOT:  state <= ST_ISSUE;
        ST_ISSUE: begin
          if (!redirect && buf_free) begin
            req_addr <= pc;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (imem_ack)      state <= ST_ISSUE;
          else if (redirect) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (imem_ack) state <= ST_ISSUE;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Output buffer: redirect clears it, an accepted fetch fills it,
  // consumption empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load_buf) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= req_addr;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule
